eye_fatigue_ctrl: RTL and testbench



---
 rtl/eye_fatigue_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_eye_fatigue_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/eye_fatigue_ctrl.sv
// eye_fatigue_ctrl: frame-level driver fatigue controller.
// Calibrates an open-eye reference height, then tracks PERCLOS and
// consecutive closed frames to raise a non-sticky fatigue alarm.
//
// Ports:
//   module_clk, module_rst_n   clock, async active-low reset
//   frame_done                 end-of-frame strobe (E0)
//   calib_start                (re)start calibration, any state
//   eye{1,2}_{up,down,left,right}  eye boxes from the detector
//   state                      0=IDLE 1=CALIB 2=RUN
//   calib_done, ref_height     calibrated reference
//   eye_closed, perclos_cnt, consec_cnt, fatigue_alarm, face_lost
//   result_val                 one-cycle pulse after each update (E2)

module eye_fatigue_ctrl #(
    parameter int CAL_LOG2   = 4,
    parameter int WIN        = 32,
    parameter int CLOSE_NUM  = 2,
    parameter int PERCLOS_TH = 12,
    parameter int CONSEC_TH  = 8,
    parameter int LOST_TH    = 30,
    parameter int MIN_REF    = 4
) (
    input  logic        module_clk,
    input  logic        module_rst_n,
    input  logic        frame_done,
    input  logic        calib_start,
    input  logic [10:0] eye1_up,
    input  logic [10:0] eye1_down,
    input  logic [10:0] eye1_left,
    input  logic [10:0] eye1_right,
    input  logic [10:0] eye2_up,
    input  logic [10:0] eye2_down,
    input  logic [10:0] eye2_left,
    input  logic [10:0] eye2_right,
    output logic [1:0]  state,
    output logic        calib_done,
    output logic [10:0] ref_height,
    output logic        eye_closed,
    output logic [6:0]  perclos_cnt,
    output logic [7:0]  consec_cnt,
    output logic        fatigue_alarm,
    output logic        face_lost,
    output logic        result_val
);

    localparam int SW = 11 + CAL_LOG2;
    localparam int CW = CAL_LOG2 + 1;

    localparam logic [CW-1:0] CAL_N   = CW'(1 << CAL_LOG2);
    localparam logic [10:0]   MIN_R   = 11'(MIN_REF);
    localparam logic [6:0]    P_TH    = 7'(PERCLOS_TH);
    localparam logic [7:0]    C_TH    = 8'(CONSEC_TH);
    localparam logic [7:0]    L_TH    = 8'(LOST_TH);
    localparam logic [10:0]   X_OFF   = 11'd640;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALIB = 2'd1,
        RUN   = 2'd2
    } st_t;

    st_t state_q, state_n;

    // pipeline flags and E1 capture
    logic        p1_q, p2_q;
    logic [10:0] eye_h_q;
    logic        frm_ok_q;

    // datapath state
    logic [SW-1:0]  sum_q, sum_n;
    logic [CW-1:0]  cnt_q, cnt_n;
    logic [WIN-1:0] win_q, win_n;
    logic [7:0]     inv_q, inv_n;
    logic [10:0]    ref_q, ref_n;
    logic           done_q, done_n;
    logic           closed_q, closed_n;
    logic [6:0]     perc_q, perc_n;
    logic [7:0]     cons_q, cons_n;
    logic           alarm_q, alarm_n;
    logic           lost_q, lost_n;
    logic           rv_q, rv_n;

    // per-eye validity and height, combinational from the inputs
    logic        e1_ok, e2_ok;
    logic [10:0] h1, h2, eye_h_c;

    always_comb begin
        e1_ok = (eye1_down > eye1_up) && (eye1_left <= eye1_right)
              && (eye1_left != X_OFF);
        e2_ok = (eye2_down > eye2_up) && (eye2_left <= eye2_right)
              && (eye2_left != X_OFF);
        h1 = eye1_down - eye1_up;
        h2 = eye2_down - eye2_up;
        eye_h_c = 11'd0;
        if (e1_ok && e2_ok)
            eye_h_c = (h1 > h2) ? h1 : h2;
        else if (e1_ok)
            eye_h_c = h1;
        else if (e2_ok)
            eye_h_c = h2;
    end

    // pipeline: a new strobe is only taken when E1 and E2 are both idle
    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            p1_q     <= 1'b0;
            p2_q     <= 1'b0;
            eye_h_q  <= 11'd0;
            frm_ok_q <= 1'b0;
        end else begin
            p1_q <= frame_done && !p1_q && !p2_q;
            p2_q <= p1_q;
            if (p1_q) begin
                eye_h_q  <= eye_h_c;
                frm_ok_q <= e1_ok || e2_ok;
            end
        end
    end

    // full-width closed test: eye_h*8 < ref*CLOSE_NUM
    logic [31:0] lhs, rhs;
    logic        closed_c;
    logic [SW-1:0] sum_add;
    logic [10:0]   ref_c;

    always_comb begin
        lhs      = {21'd0, eye_h_q} << 3;
        rhs      = {21'd0, ref_q} * 32'(CLOSE_NUM);
        closed_c = lhs < rhs;
        sum_add  = sum_q + SW'(eye_h_q);
        ref_c    = 11'(sum_add >> CAL_LOG2);
    end

    always_comb begin
        state_n  = state_q;
        sum_n    = sum_q;
        cnt_n    = cnt_q;
        win_n    = win_q;
        inv_n    = inv_q;
        ref_n    = ref_q;
        done_n   = done_q;
        closed_n = closed_q;
        perc_n   = perc_q;
        cons_n   = cons_q;
        alarm_n  = alarm_q;
        lost_n   = lost_q;
        rv_n     = 1'b0;

        if (calib_start) begin
            state_n  = CALIB;
            sum_n    = '0;
            cnt_n    = '0;
            win_n    = '0;
            inv_n    = '0;
            done_n   = 1'b0;
            closed_n = 1'b0;
            perc_n   = '0;
            cons_n   = '0;
            alarm_n  = 1'b0;
            lost_n   = 1'b0;
        end else if (p2_q && state_q != IDLE) begin
            rv_n = 1'b1;
            if (state_q == CALIB) begin
                if (frm_ok_q) begin
                    if (cnt_q + 1'b1 == CAL_N) begin
                        sum_n = '0;
                        cnt_n = '0;
                        if (ref_c >= MIN_R) begin
                            ref_n   = ref_c;
                            done_n  = 1'b1;
                            state_n = RUN;
                        end
                    end else begin
                        sum_n = sum_add;
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end else begin
                if (frm_ok_q) begin
                    closed_n = closed_c;
                    win_n    = {win_q[WIN-2:0], closed_c};
                    perc_n   = perc_q + {6'd0, closed_c}
                             - {6'd0, win_q[WIN-1]};
                    if (!closed_c)
                        cons_n = '0;
                    else if (cons_q != 8'hFF)
                        cons_n = cons_q + 8'd1;
                    inv_n = '0;
                end else if (inv_q != 8'hFF) begin
                    inv_n = inv_q + 8'd1;
                end
                lost_n  = inv_n >= L_TH;
                alarm_n = (perc_n >= P_TH) || (cons_n >= C_TH);
            end
        end
    end

    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            sum_q    <= '0;
            cnt_q    <= '0;
            win_q    <= '0;
            inv_q    <= '0;
            ref_q    <= '0;
            done_q   <= 1'b0;
            closed_q <= 1'b0;
            perc_q   <= '0;
            cons_q   <= '0;
            alarm_q  <= 1'b0;
            lost_q   <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            sum_q    <= sum_n;
            cnt_q    <= cnt_n;
            win_q    <= win_n;
            inv_q    <= inv_n;
            ref_q    <= ref_n;
            done_q   <= done_n;
            closed_q <= closed_n;
            perc_q   <= perc_n;
            cons_q   <= cons_n;
            alarm_q  <= alarm_n;
            lost_q   <= lost_n;
            rv_q     <= rv_n;
        end
    end

    assign state         = state_q;
    assign calib_done    = done_q;
    assign ref_height    = ref_q;
    assign eye_closed    = closed_q;
    assign perclos_cnt   = perc_q;
    assign consec_cnt    = cons_q;
    assign fatigue_alarm = alarm_q;
    assign face_lost     = lost_q;
    assign result_val    = rv_q;

endmodule

// File: tb/tb_eye_fatigue_ctrl.sv
// tb_eye_fatigue_ctrl: directed bench for eye_fatigue_ctrl.
// Hand-computed expectations for calibration, PERCLOS, alarm, face loss.

module tb_eye_fatigue_ctrl;

    logic        module_clk;
    logic        module_rst_n;
    logic        frame_done;
    logic        calib_start;
    logic [10:0] eye1_up, eye1_down, eye1_left, eye1_right;
    logic [10:0] eye2_up, eye2_down, eye2_left, eye2_right;
    logic [1:0]  state;
    logic        calib_done;
    logic [10:0] ref_height;
    logic        eye_closed;
    logic [6:0]  perclos_cnt;
    logic [7:0]  consec_cnt;
    logic        fatigue_alarm;
    logic        face_lost;
    logic        result_val;

    int checks = 0;
    int errors = 0;
    int rv_cnt = 0;
    int rv_mark;

    eye_fatigue_ctrl dut (
        .module_clk    (module_clk),
        .module_rst_n  (module_rst_n),
        .frame_done    (frame_done),
        .calib_start   (calib_start),
        .eye1_up       (eye1_up),
        .eye1_down     (eye1_down),
        .eye1_left     (eye1_left),
        .eye1_right    (eye1_right),
        .eye2_up       (eye2_up),
        .eye2_down     (eye2_down),
        .eye2_left     (eye2_left),
        .eye2_right    (eye2_right),
        .state         (state),
        .calib_done    (calib_done),
        .ref_height    (ref_height),
        .eye_closed    (eye_closed),
        .perclos_cnt   (perclos_cnt),
        .consec_cnt    (consec_cnt),
        .fatigue_alarm (fatigue_alarm),
        .face_lost     (face_lost),
        .result_val    (result_val)
    );

    initial module_clk = 1'b0;
    always #5 module_clk = ~module_clk;

    always @(negedge module_clk)
        if (result_val) rv_cnt++;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // one frame: eye1 height h1 (valid v1), eye2 height h2 (valid v2)
    task automatic frame(input int h1, input bit v1,
                         input int h2, input bit v2);
        @(negedge module_clk);
        eye1_up    = 11'd100;
        eye1_down  = 11'(100 + h1);
        eye1_left  = v1 ? 11'd200 : 11'd640;
        eye1_right = 11'd260;
        eye2_up    = 11'd100;
        eye2_down  = 11'(100 + h2);
        eye2_left  = v2 ? 11'd400 : 11'd640;
        eye2_right = 11'd460;
        frame_done = 1'b1;
        @(negedge module_clk);
        frame_done = 1'b0;
        repeat (4) @(negedge module_clk);
    endtask

    task automatic start_cal();
        @(negedge module_clk);
        calib_start = 1'b1;
        @(negedge module_clk);
        calib_start = 1'b0;
    endtask

    task automatic cal12();
        start_cal();
        for (int i = 0; i < 16; i++) frame(12, 1, 12, 1);
    endtask

    initial begin
        module_rst_n = 1'b0;
        frame_done   = 1'b0;
        calib_start  = 1'b0;
        eye1_up = '0; eye1_down = '0; eye1_left = '0; eye1_right = '0;
        eye2_up = '0; eye2_down = '0; eye2_left = '0; eye2_right = '0;
        repeat (3) @(negedge module_clk);
        chk("rst_state", state, 0);
        chk("rst_done", calib_done, 0);
        chk("rst_ref", ref_height, 0);
        chk("rst_alarm", fatigue_alarm, 0);
        chk("rst_rv", result_val, 0);
        module_rst_n = 1'b1;

        // idle frames produce nothing
        frame(10, 1, 10, 1);
        chk("idle_rv", rv_cnt, 0);
        chk("idle_state", state, 0);

        // calibration at height 10
        start_cal();
        chk("cal_state", state, 1);
        for (int i = 0; i < 16; i++) frame(10, 1, 10, 0);
        chk("cal10_state", state, 2);
        chk("cal10_ref", ref_height, 10);
        chk("cal10_done", calib_done, 1);
        chk("cal10_rv", rv_cnt, 16);

        // too small a reference, then a good one
        start_cal();
        chk("recal_done", calib_done, 0);
        for (int i = 0; i < 16; i++) frame(2, 1, 2, 1);
        chk("cal2_state", state, 1);
        chk("cal2_done", calib_done, 0);
        for (int i = 0; i < 16; i++) frame(12, 1, 1, 1);
        chk("cal12_state", state, 2);
        chk("cal12_ref", ref_height, 12);

        // consecutive closed frames
        for (int i = 1; i <= 8; i++) begin
            frame(2, 1, 2, 1);
            if (i == 7) begin
                chk("cons7_cnt", consec_cnt, 7);
                chk("cons7_alarm", fatigue_alarm, 0);
            end
        end
        chk("cons8_cnt", consec_cnt, 8);
        chk("cons8_alarm", fatigue_alarm, 1);
        chk("cons8_closed", eye_closed, 1);
        chk("cons8_perc", perclos_cnt, 8);
        // max of two eyes: 12 wins over 2
        frame(2, 1, 12, 1);
        chk("open_cons", consec_cnt, 0);
        chk("open_alarm", fatigue_alarm, 0);
        chk("open_closed", eye_closed, 0);
        chk("open_perc", perclos_cnt, 8);
        // boundary: 3*8 = 24 is not < 24
        frame(3, 1, 3, 1);
        chk("bnd3_closed", eye_closed, 0);
        frame(2, 0, 2, 1);
        chk("bnd2_closed", eye_closed, 1);
        chk("bnd2_perc", perclos_cnt, 9);

        // alternating closed/open, window wrap
        cal12();
        chk("alt_cal_perc", perclos_cnt, 0);
        for (int i = 1; i <= 40; i++) begin
            if (i % 2 == 1) frame(2, 1, 2, 1);
            else            frame(12, 1, 12, 1);
            if (i == 22) begin
                chk("alt22_perc", perclos_cnt, 11);
                chk("alt22_alarm", fatigue_alarm, 0);
            end
            if (i == 23) begin
                chk("alt23_perc", perclos_cnt, 12);
                chk("alt23_alarm", fatigue_alarm, 1);
            end
            if (i == 33) chk("alt33_perc", perclos_cnt, 16);
        end
        chk("alt40_perc", perclos_cnt, 16);
        chk("alt40_alarm", fatigue_alarm, 1);
        chk("alt40_cons", consec_cnt, 0);

        // face lost
        for (int i = 1; i <= 30; i++) begin
            frame(12, 0, 12, 0);
            if (i == 29) chk("lost29", face_lost, 0);
        end
        chk("lost30", face_lost, 1);
        chk("lost_perc", perclos_cnt, 16);
        chk("lost_closed", eye_closed, 0);
        frame(12, 1, 12, 1);
        chk("found", face_lost, 0);
        chk("found_perc", perclos_cnt, 15);

        // repeated strobe on E1 and calib_start on E2
        rv_mark = rv_cnt;
        @(negedge module_clk);
        frame_done = 1'b1;
        @(negedge module_clk);
        frame_done = 1'b1;
        @(negedge module_clk);
        frame_done  = 1'b0;
        calib_start = 1'b1;
        @(negedge module_clk);
        calib_start = 1'b0;
        repeat (6) @(negedge module_clk);
        chk("ovr_rv", rv_cnt - rv_mark, 0);
        chk("ovr_state", state, 1);
        chk("ovr_perc", perclos_cnt, 0);
        chk("ovr_cons", consec_cnt, 0);
        chk("ovr_alarm", fatigue_alarm, 0);
        chk("ovr_done", calib_done, 0);
        chk("ovr_lost", face_lost, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
